// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-bus sequencer: turns a load/store into one SRAM-like req/addr_ok/data_ok
// transaction, stalls the pipeline while it is outstanding and captures the raw read word.
module dmem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_flag_i,
    input  logic                  mem_write_flag_i,
    input  logic [3:0]            mem_sel_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_write_data_i,
    input  logic                  flush_i,
    output logic                  data_sram_req_o,
    output logic                  data_sram_wr_o,
    output logic [1:0]            data_sram_size_o,
    output logic [ADDR_WIDTH-1:0] data_sram_addr_o,
    output logic [3:0]            data_sram_wstrb_o,
    output logic [DATA_WIDTH-1:0] data_sram_wdata_o,
    input  logic                  data_sram_addr_ok_i,
    input  logic                  data_sram_data_ok_i,
    input  logic [DATA_WIDTH-1:0] data_sram_rdata_i,
    output logic                  stall_req_o,
    output logic [DATA_WIDTH-1:0] ram_read_data_o,
    output logic                  read_valid_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_n;
    logic   drain_q, drain_n;
    logic   aligned;
    logic   access;
    logic   capture;

    function automatic logic [1:0] enc_size(input logic [3:0] sel);
        case (sel)
            4'b0001: enc_size = 2'd0;
            4'b0011: enc_size = 2'd1;
            default: enc_size = 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] enc_wstrb(input logic [3:0] sel, input logic [1:0] a);
        case (sel)
            4'b0001: enc_wstrb = 4'b0001 << a;
            4'b0011: enc_wstrb = a[1] ? 4'b1100 : 4'b0011;
            default: enc_wstrb = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] enc_wdata(input logic [3:0] sel,
                                                        input logic [DATA_WIDTH-1:0] wd);
        case (sel)
            4'b0001: enc_wdata = {4{wd[7:0]}};
            4'b0011: enc_wdata = {2{wd[15:0]}};
            default: enc_wdata = wd;
        endcase
    endfunction

    always_comb begin
        case (mem_sel_i)
            4'b0001: aligned = 1'b1;
            4'b0011: aligned = ~mem_addr_i[0];
            4'b1111: aligned = (mem_addr_i[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign access = (mem_read_flag_i | mem_write_flag_i) & aligned & ~flush_i;

    // A load result is kept only if the access was never squashed.
    assign capture = ~data_sram_wr_o & data_sram_data_ok_i & ~flush_i & ~drain_q &
                     (((state == REQ) & data_sram_addr_ok_i) | (state == WAIT));

    always_comb begin
        state_n = state;
        drain_n = drain_q;
        case (state)
            IDLE: begin
                drain_n = 1'b0;
                if (access) state_n = REQ;
            end
            REQ: begin
                if (data_sram_addr_ok_i) begin
                    if (data_sram_data_ok_i) begin
                        state_n = flush_i ? IDLE : DONE;
                    end else begin
                        state_n = WAIT;
                        drain_n = flush_i;
                    end
                end else if (flush_i) begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (data_sram_data_ok_i) begin
                    state_n = (drain_q | flush_i) ? IDLE : DONE;
                    drain_n = 1'b0;
                end else if (flush_i) begin
                    drain_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            drain_q           <= 1'b0;
            data_sram_wr_o    <= 1'b0;
            data_sram_size_o  <= 2'd0;
            data_sram_addr_o  <= '0;
            data_sram_wstrb_o <= 4'b0000;
            data_sram_wdata_o <= '0;
            ram_read_data_o   <= '0;
        end else begin
            state   <= state_n;
            drain_q <= drain_n;
            // Bus fields are frozen for the whole transaction once the request starts.
            if ((state == IDLE) && access) begin
                data_sram_wr_o    <= mem_write_flag_i;
                data_sram_size_o  <= enc_size(mem_sel_i);
                data_sram_addr_o  <= mem_addr_i;
                data_sram_wstrb_o <= mem_write_flag_i ? enc_wstrb(mem_sel_i, mem_addr_i[1:0]) : 4'b0000;
                data_sram_wdata_o <= mem_write_flag_i ? enc_wdata(mem_sel_i, mem_write_data_i) : '0;
            end
            if (capture) ram_read_data_o <= data_sram_rdata_i;
        end
    end

    assign data_sram_req_o = (state == REQ);
    assign stall_req_o     = ((state == IDLE) & access) | (state == REQ) | (state == WAIT);
    assign read_valid_o    = (state == DONE) & ~data_sram_wr_o;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: cycle-level bus checks plus a load-result scoreboard.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag_i, mem_write_flag_i, flush_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i, mem_write_data_i;
    logic        data_sram_req_o, data_sram_wr_o;
    logic [1:0]  data_sram_size_o;
    logic [31:0] data_sram_addr_o, data_sram_wdata_o;
    logic [3:0]  data_sram_wstrb_o;
    logic        data_sram_addr_ok_i, data_sram_data_ok_i;
    logic [31:0] data_sram_rdata_i;
    logic        stall_req_o, read_valid_o;
    logic [31:0] ram_read_data_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_read_flag_i     (mem_read_flag_i),
        .mem_write_flag_i    (mem_write_flag_i),
        .mem_sel_i           (mem_sel_i),
        .mem_addr_i          (mem_addr_i),
        .mem_write_data_i    (mem_write_data_i),
        .flush_i             (flush_i),
        .data_sram_req_o     (data_sram_req_o),
        .data_sram_wr_o      (data_sram_wr_o),
        .data_sram_size_o    (data_sram_size_o),
        .data_sram_addr_o    (data_sram_addr_o),
        .data_sram_wstrb_o   (data_sram_wstrb_o),
        .data_sram_wdata_o   (data_sram_wdata_o),
        .data_sram_addr_ok_i (data_sram_addr_ok_i),
        .data_sram_data_ok_i (data_sram_data_ok_i),
        .data_sram_rdata_i   (data_sram_rdata_i),
        .stall_req_o         (stall_req_o),
        .ram_read_data_o     (ram_read_data_o),
        .read_valid_o        (read_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=unexpected_read_valid expected=no_pending_load", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, ram_read_data_o, e);
        end
    endtask

    // Advance to just after the next rising edge; new inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mem_read_flag_i     = 1'b0;
        mem_write_flag_i    = 1'b0;
        flush_i             = 1'b0;
        data_sram_addr_ok_i = 1'b0;
        data_sram_data_ok_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus_idle();
        mem_sel_i = 4'b0000; mem_addr_i = '0; mem_write_data_i = '0; data_sram_rdata_i = '0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_req", data_sram_req_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_rv", read_valid_o, 0);
        chk("rst_rdata", ram_read_data_o, 0);
        chk("rst_fields", {data_sram_wr_o, data_sram_size_o, data_sram_wstrb_o}, 0);
        chk("rst_addr", data_sram_addr_o, 0);
        chk("rst_wdata", data_sram_wdata_o, 0);

        // lb 0x1003, data_ok two cycles after addr_ok
        tick(); mem_read_flag_i = 1'b1; mem_sel_i = 4'b0001; mem_addr_i = 32'h1003;
        exp_q.push_back(32'h80FF_0000); #1;
        chk("lb_stall0", stall_req_o, 1); chk("lb_req0", data_sram_req_o, 0);
        tick(); data_sram_addr_ok_i = 1'b1; #1;
        chk("lb_req1", data_sram_req_o, 1); chk("lb_stall1", stall_req_o, 1);
        chk("lb_wr", data_sram_wr_o, 0); chk("lb_size", data_sram_size_o, 0);
        chk("lb_wstrb", data_sram_wstrb_o, 0); chk("lb_addr", data_sram_addr_o, 32'h1003);
        tick(); data_sram_addr_ok_i = 1'b0; #1;
        chk("lb_req2", data_sram_req_o, 0); chk("lb_stall2", stall_req_o, 1);
        tick(); data_sram_data_ok_i = 1'b1; data_sram_rdata_i = 32'h80FF_0000; #1;
        chk("lb_stall3", stall_req_o, 1); chk("lb_rv3", read_valid_o, 0);
        tick(); bus_idle(); data_sram_rdata_i = 32'hDEAD_BEEF; #1;
        chk("lb_stall4", stall_req_o, 0); chk("lb_rv4", read_valid_o, 1);
        if (read_valid_o) pop_chk("lb_rdata");
        tick(); #1;
        chk("lb_rv5", read_valid_o, 0); chk("lb_hold", ram_read_data_o, 32'h80FF_0000);

        // sh 0x2002
        mem_write_flag_i = 1'b1; mem_sel_i = 4'b0011; mem_addr_i = 32'h2002;
        mem_write_data_i = 32'h0000_BEEF; #1;
        chk("sh_stall0", stall_req_o, 1);
        tick(); data_sram_addr_ok_i = 1'b1; data_sram_data_ok_i = 1'b1; #1;
        chk("sh_req", data_sram_req_o, 1); chk("sh_wr", data_sram_wr_o, 1);
        chk("sh_size", data_sram_size_o, 1); chk("sh_wstrb", data_sram_wstrb_o, 4'b1100);
        chk("sh_wdata", data_sram_wdata_o, 32'hBEEF_BEEF);
        tick(); bus_idle(); #1;
        chk("sh_stall_done", stall_req_o, 0); chk("sh_rv", read_valid_o, 0);
        tick();

        // sb 0x3001
        mem_write_flag_i = 1'b1; mem_sel_i = 4'b0001; mem_addr_i = 32'h3001;
        mem_write_data_i = 32'h0000_00AB; #1;
        tick(); data_sram_addr_ok_i = 1'b1; data_sram_data_ok_i = 1'b1; #1;
        chk("sb_wr", data_sram_wr_o, 1); chk("sb_size", data_sram_size_o, 0);
        chk("sb_wstrb", data_sram_wstrb_o, 4'b0010); chk("sb_wdata", data_sram_wdata_o, 32'hABAB_ABAB);
        tick(); bus_idle(); #1;
        chk("sb_rv", read_valid_o, 0);
        tick();

        // lw 0x4000 with addr_ok withheld for three cycles; input address wanders meanwhile
        mem_read_flag_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h4000;
        exp_q.push_back(32'h1234_5678); #1;
        for (int i = 0; i < 3; i++) begin
            tick(); mem_addr_i = 32'h0000_5550 + 32'(i * 4); #1;
            chk("lw_req_hold", data_sram_req_o, 1);
            chk("lw_addr_hold", data_sram_addr_o, 32'h4000);
            chk("lw_fields_hold", {data_sram_wr_o, data_sram_size_o, data_sram_wstrb_o}, {1'b0, 2'd2, 4'b0000});
        end
        tick(); data_sram_addr_ok_i = 1'b1; data_sram_data_ok_i = 1'b1; data_sram_rdata_i = 32'h1234_5678; #1;
        chk("lw_req_ok", data_sram_req_o, 1);
        tick(); bus_idle(); #1;
        chk("lw_rv", read_valid_o, 1); chk("lw_req_done", data_sram_req_o, 0);
        if (read_valid_o) pop_chk("lw_rdata");
        tick();

        // misaligned lw 0x0002
        mem_read_flag_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h0002; #1;
        for (int i = 0; i < 3; i++) begin
            chk("mis_stall", stall_req_o, 0); chk("mis_req", data_sram_req_o, 0);
            tick();
        end
        bus_idle();

        // access coincident with flush in IDLE is never issued
        mem_read_flag_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h0010; flush_i = 1'b1; #1;
        chk("fidle_stall", stall_req_o, 0);
        tick(); bus_idle(); #1;
        chk("fidle_req", data_sram_req_o, 0);

        // flush in WAIT, data_ok one cycle later: discarded
        tick(); mem_read_flag_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h6000; #1;
        tick(); data_sram_addr_ok_i = 1'b1; #1;
        tick(); data_sram_addr_ok_i = 1'b0; flush_i = 1'b1; #1;
        chk("fw_stall0", stall_req_o, 1);
        tick(); bus_idle(); data_sram_data_ok_i = 1'b1; data_sram_rdata_i = 32'hBADB_AD00; #1;
        chk("fw_stall1", stall_req_o, 1); chk("fw_rv1", read_valid_o, 0);
        tick(); bus_idle(); #1;
        chk("fw_stall2", stall_req_o, 0); chk("fw_rv2", read_valid_o, 0);
        chk("fw_keep", ram_read_data_o, 32'h1234_5678);
        tick(); #1;
        chk("fw_rv3", read_valid_o, 0);

        // flush in REQ before addr_ok
        mem_read_flag_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h7000; #1;
        tick(); flush_i = 1'b1; #1;
        chk("fr_req0", data_sram_req_o, 1);
        tick(); bus_idle(); #1;
        chk("fr_req1", data_sram_req_o, 0); chk("fr_stall1", stall_req_o, 0);

        // reset in the middle of a transaction; late data_ok ignored
        tick(); mem_read_flag_i = 1'b1; mem_sel_i = 4'b1111; mem_addr_i = 32'h8000; #1;
        tick(); data_sram_addr_ok_i = 1'b1; #1;
        tick(); data_sram_addr_ok_i = 1'b0; rst = 1'b1; #1;
        tick(); rst = 1'b0; bus_idle(); data_sram_data_ok_i = 1'b1; data_sram_rdata_i = 32'hFFFF_FFFF; #1;
        chk("rm_req", data_sram_req_o, 0); chk("rm_stall", stall_req_o, 0);
        tick(); bus_idle(); #1;
        chk("rm_rv", read_valid_o, 0); chk("rm_rdata", ram_read_data_o, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
